// File: rtl/hdmi_pattern_sequencer.sv
// Test-pattern sequencer: steps/auto-cycles the pattern select and sequences resolution changes
// with black frames. Define HDMI_PATTERN_SEQ_DEBOUNCE_EN to debounce raw key levels.
module hdmi_pattern_sequencer #(
  parameter int NUM_PATTERNS    = 9,
  parameter int DWELL_FRAMES    = 60,
  parameter int BLANK_FRAMES    = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       frame_start,
  input  logic       auto_en,
  input  logic       key_next,
  input  logic       key_prev,
  input  logic [1:0] res_req,
  input  logic       res_req_valid,
  output logic [3:0] cs,
  output logic [1:0] Resolution_code,
  output logic       pattern_change,
  output logic       busy
);

  typedef enum logic [1:0] {MANUAL, AUTO, RES_WAIT, RES_BLANK} state_e;
  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_BACK} step_e;

  localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES + 1) : 1;
  localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);
  localparam logic [3:0]    CS_LAST    = 4'(NUM_PATTERNS - 1);
  localparam logic [3:0]    CS_BLACK   = 4'd1;

  state_e        state_q;
  step_e         step_q;
  step_e         stepNext;
  logic [3:0]    cs_q;
  logic [3:0]    savedCs_q;
  logic [1:0]    res_q;
  logic [1:0]    pendRes_q;
  logic [DW-1:0] dwellCnt_q;
  logic [BW-1:0] blankCnt_q;
  logic          patternChange_q;
  logic          busy_q;

  logic          nextReq;
  logic          prevReq;
  logic [3:0]    csInc;
  logic [3:0]    csDec;
  logic [1:0]    reqCode;

`ifdef HDMI_PATTERN_SEQ_DEBOUNCE_EN
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [1:0]     keyRaw;
  logic [1:0]     sync1_q;
  logic [1:0]     sync2_q;
  logic [1:0]     stable_q;
  logic [1:0]     req_q;
  logic [DBW-1:0] dbCnt_q [2];

  assign keyRaw = {key_prev, key_next};

  // A key level must hold for DEBOUNCE_CYCLES before it is accepted; a request fires on the accepted rise.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      req_q    <= '0;
      for (int k = 0; k < 2; k++) dbCnt_q[k] <= '0;
    end else begin
      sync1_q <= keyRaw;
      sync2_q <= sync1_q;
      req_q   <= '0;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == stable_q[k]) begin
          dbCnt_q[k] <= '0;
        end else if (dbCnt_q[k] >= DBW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q[k] <= sync2_q[k];
          req_q[k]    <= sync2_q[k];
          dbCnt_q[k]  <= '0;
        end else begin
          dbCnt_q[k] <= dbCnt_q[k] + DBW'(1);
        end
      end
    end
  end

  assign nextReq = req_q[0];
  assign prevReq = req_q[1];
`else
  assign nextReq = key_next;
  assign prevReq = key_prev;
`endif

  assign csInc   = (cs_q == CS_LAST) ? 4'd0 : cs_q + 4'd1;
  assign csDec   = (cs_q == 4'd0) ? CS_LAST : cs_q - 4'd1;
  assign reqCode = (res_req == 2'b11) ? 2'b00 : res_req;

  // A step consumed by frame_start is cleared, but a press in the same cycle still becomes pending.
  always_comb begin
    stepNext = step_q;
    if (frame_start) stepNext = STEP_NONE;
    if (nextReq && prevReq) stepNext = STEP_NONE;
    else if (nextReq)       stepNext = STEP_FWD;
    else if (prevReq)       stepNext = STEP_BACK;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q         <= MANUAL;
      step_q          <= STEP_NONE;
      cs_q            <= 4'd0;
      savedCs_q       <= 4'd0;
      res_q           <= 2'b00;
      pendRes_q       <= 2'b00;
      dwellCnt_q      <= '0;
      blankCnt_q      <= '0;
      patternChange_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      patternChange_q <= 1'b0;
      case (state_q)
        MANUAL, AUTO: begin
          if (res_req_valid && (reqCode != res_q)) begin
            pendRes_q <= reqCode;
            savedCs_q <= cs_q;
            state_q   <= RES_WAIT;
            busy_q    <= 1'b1;
            step_q    <= STEP_NONE;
          end else begin
            step_q <= stepNext;
            if (frame_start) begin
              if (step_q == STEP_FWD) begin
                cs_q            <= csInc;
                patternChange_q <= (csInc != cs_q);
                dwellCnt_q      <= '0;
              end else if (step_q == STEP_BACK) begin
                cs_q            <= csDec;
                patternChange_q <= (csDec != cs_q);
                dwellCnt_q      <= '0;
              end else if (state_q == AUTO) begin
                if (dwellCnt_q >= DWELL_LAST) begin
                  cs_q            <= csInc;
                  patternChange_q <= (csInc != cs_q);
                  dwellCnt_q      <= '0;
                end else begin
                  dwellCnt_q <= dwellCnt_q + DW'(1);
                end
              end
            end
            // Mode switches restart the dwell period; cs is left as it is.
            if ((state_q == MANUAL) && auto_en) begin
              state_q    <= AUTO;
              dwellCnt_q <= '0;
            end else if ((state_q == AUTO) && !auto_en) begin
              state_q    <= MANUAL;
              dwellCnt_q <= '0;
            end
          end
        end
        RES_WAIT: begin
          if (frame_start) begin
            res_q           <= res_req_valid ? reqCode : pendRes_q;
            cs_q            <= CS_BLACK;
            patternChange_q <= (cs_q != CS_BLACK);
            blankCnt_q      <= '0;
            state_q         <= RES_BLANK;
          end else if (res_req_valid) begin
            pendRes_q <= reqCode;
          end
        end
        RES_BLANK: begin
          if (res_req_valid && (reqCode != res_q)) begin
            pendRes_q <= reqCode;
            state_q   <= RES_WAIT;
          end else if (frame_start) begin
            if (blankCnt_q >= BLANK_LAST) begin
              cs_q            <= savedCs_q;
              patternChange_q <= (savedCs_q != cs_q);
              blankCnt_q      <= '0;
              dwellCnt_q      <= '0;
              busy_q          <= 1'b0;
              state_q         <= auto_en ? AUTO : MANUAL;
            end else begin
              blankCnt_q <= blankCnt_q + BW'(1);
            end
          end
        end
        default: state_q <= MANUAL;
      endcase
    end
  end

  assign cs              = cs_q;
  assign Resolution_code = res_q;
  assign pattern_change  = patternChange_q;
  assign busy            = busy_q;

endmodule

// File: doc/hdmi_pattern_sequencer.md
HDMI_PATTERN_SEQUENCER -- requirements
Module: hdmi_pattern_sequencer

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 9, number of selectable patterns; cs range is 0..NUM_PATTERNS-1.
REQ-002 SHALL have parameter DWELL_FRAMES, default 60, frames each pattern is shown in auto mode.
REQ-003 SHALL have parameter BLANK_FRAMES, default 2, black frames inserted after a resolution change.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, key stable time in clk cycles; used only when debounce is compiled in.
REQ-005 SHALL have port clk  input  1  pixel/VGA drive clock; the block has one clock.
REQ-006 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-008 SHALL have port auto_en  input  1  level; 1 = auto-cycle patterns, 0 = manual.
REQ-009 SHALL have port key_next  input  1  step-forward request.
REQ-010 SHALL have port key_prev  input  1  step-backward request.
REQ-011 SHALL have port res_req  input  2  requested resolution code (00 640x480, 01 1024x768, 10 800x600).
REQ-012 SHALL have port res_req_valid  input  1  one-cycle strobe qualifying res_req.
REQ-013 SHALL have port cs  output  4  pattern select to the pattern generator.
REQ-014 SHALL have port Resolution_code  output  2  applied resolution code to generator and timing.
REQ-015 SHALL have port pattern_change  output  1  one-cycle pulse when cs changes value.
REQ-016 SHALL have port busy  output  1  high while a resolution change is in progress.

Function
REQ-017 SHALL implement states MANUAL, AUTO, RES_WAIT, RES_BLANK; all outputs registered.
REQ-018 SHALL change cs and Resolution_code only in the cycle after a frame_start pulse (values visible one cycle after frame_start).
REQ-019 SHALL hold one pending step (+1/-1), latest press overriding; key_next and key_prev in the same cycle cancel each other and clear the pending step.
REQ-020 SHALL on frame_start with pending step apply cs+1 wrapping NUM_PATTERNS-1->0, or cs-1 wrapping 0->NUM_PATTERNS-1, then clear the pending step.
REQ-021 SHALL in AUTO count frame_start pulses; on the pulse where the count equals DWELL_FRAMES-1, advance cs by +1 with wrap and clear the count.
REQ-022 SHALL in AUTO clear the dwell count when a pending step is applied.
REQ-023 SHALL move MANUAL->AUTO when auto_en=1 and AUTO->MANUAL when auto_en=0, in the next cycle, clearing the dwell count; cs is held.
REQ-024 SHALL on res_req_valid with mapped code different from Resolution_code latch the code, save cs, enter RES_WAIT, assert busy; res_req=11 maps to 00; an equal code is ignored.
REQ-025 SHALL in RES_WAIT on frame_start update Resolution_code, force cs=1 (black), enter RES_BLANK, clear the blank count.
REQ-026 SHALL in RES_BLANK count frame_start pulses; after BLANK_FRAMES pulses restore saved cs and enter AUTO if auto_en=1 else MANUAL, deassert busy.
REQ-027 SHALL in RES_WAIT overwrite the latched code on a new res_req_valid; in RES_BLANK a new differing code returns to RES_WAIT with saved cs unchanged.
REQ-028 SHALL ignore and discard key requests while busy.
REQ-029 SHALL pulse pattern_change exactly in the cycle cs takes a new value, including force-to-black and restore; not when the value is unchanged.

Reset
REQ-030 SHALL on sys_rst_n=0 immediately set cs=0, Resolution_code=00, pattern_change=0, busy=0, state MANUAL, all counters, pending step and saved cs to 0.
REQ-031 SHALL abandon any in-progress resolution change on reset.

Configuration
REQ-032 SHALL with macro HDMI_PATTERN_SEQ_DEBOUNCE_EN defined treat key_next/key_prev as raw levels: a 2-flop synchronizer, DEBOUNCE_CYCLES stability filter, and rising-edge detect produce one request per press.
REQ-033 SHALL without HDMI_PATTERN_SEQ_DEBOUNCE_EN treat key_next/key_prev as synchronous one-cycle pulses, one request per high cycle.

Verification (debounce off, NUM_PATTERNS=9, DWELL_FRAMES=3, BLANK_FRAMES=2)
REQ-034 SHALL cover: reset, auto_en=0, key_prev pulse, frame_start -> cs=8, pattern_change one pulse.
REQ-035 SHALL cover: auto_en=1, 6 frame_start pulses -> cs 0->1 on 3rd, 1->2 on 6th.
REQ-036 SHALL cover: key_next and key_prev same cycle, frame_start -> cs unchanged, no pattern_change.
REQ-037 SHALL cover: cs=5, res_req=01 valid, 3 frame_start pulses -> busy=1, Resolution_code=01 and cs=1 after 1st, cs=5 and busy=0 after 3rd.
REQ-038 SHALL cover: res_req=11 while Resolution_code=00 -> ignored, busy stays 0; sys_rst_n low during RES_BLANK -> cs=0, Resolution_code=00, busy=0 immediately.
